// File: rtl/fp_pkg.sv
// Shared floating-point helpers: operand class encoding, exception flag bit
// positions, and format-dependent constants derived from EXP_W/MAN_W.
package fp_pkg;

    typedef enum logic [1:0] {
        FP_ZERO = 2'd0,
        FP_NORM = 2'd1,
        FP_INF  = 2'd2,
        FP_NAN  = 2'd3
    } fp_class_e;

    localparam int FLG_INVALID = 3;
    localparam int FLG_OVF     = 2;
    localparam int FLG_UNF     = 1;
    localparam int FLG_INX     = 0;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Returned right-aligned in a wide word; callers size-cast to their format.
    function automatic logic [127:0] fp_qnan(input int exp_w, input int man_w);
        logic [127:0] one;
        one = 128'd1;
        return (((one << exp_w) - one) << man_w) | (one << (man_w - 1));
    endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Normalise, round-to-nearest-even and pack a raw mantissa product; special
// operand classes decided upstream override the arithmetic result.
module fp_round_pack
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                    sign_i,
    input  logic signed [EXP_W+1:0] exp_i,
    input  logic [2*MAN_W+1:0]      prod_i,
    input  fp_class_e               cls_i,
    input  logic                    invalid_i,
    output logic [EXP_W+MAN_W:0]    word_o,
    output logic [3:0]              flags_o
);

    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int EW2 = EXP_W + 2;
    localparam int PW  = 2 * MAN_W + 2;

    localparam logic signed [EW2-1:0] E_ONE  = EW2'(1);
    localparam logic signed [EW2-1:0] E_ZERO = '0;
    localparam logic signed [EW2-1:0] E_MAX  = EW2'((1 << EXP_W) - 1);
    localparam logic [W-1:0]          QNAN   = W'(fp_qnan(EXP_W, MAN_W));

    function automatic logic rne_inc(input logic lsb, input logic guard, input logic sticky);
        return guard && (sticky || lsb);
    endfunction

    logic                  hi;
    logic [MAN_W-1:0]      frac_k;
    logic                  guard;
    logic                  sticky;
    logic [MAN_W:0]        frac_r;
    logic signed [EW2-1:0] exp_r;

    always_comb begin
        hi = prod_i[PW-1];
        if (hi) begin
            frac_k = prod_i[PW-2 -: MAN_W];
            guard  = prod_i[MAN_W];
            sticky = |prod_i[MAN_W-1:0];
        end else begin
            frac_k = prod_i[PW-3 -: MAN_W];
            guard  = prod_i[MAN_W-1];
            sticky = |prod_i[MAN_W-2:0];
        end
        // A rounding carry leaves the fraction at zero and bumps the exponent.
        frac_r = {1'b0, frac_k} + {{MAN_W{1'b0}}, rne_inc(frac_k[0], guard, sticky)};
        exp_r  = exp_i + (hi ? E_ONE : E_ZERO) + (frac_r[MAN_W] ? E_ONE : E_ZERO);

        word_o  = '0;
        flags_o = '0;
        case (cls_i)
            FP_NAN: begin
                word_o               = QNAN;
                flags_o[FLG_INVALID] = invalid_i;
            end
            FP_INF:  word_o = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            FP_ZERO: word_o = {sign_i, {(W-1){1'b0}}};
            default: begin
                if (exp_r <= E_ZERO) begin
                    word_o           = {sign_i, {(W-1){1'b0}}};
                    flags_o[FLG_UNF] = 1'b1;
                    flags_o[FLG_INX] = 1'b1;
                end else if (exp_r >= E_MAX) begin
                    word_o           = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    flags_o[FLG_OVF] = 1'b1;
                    flags_o[FLG_INX] = 1'b1;
                end else begin
                    word_o           = {sign_i, exp_r[EXP_W-1:0], frac_r[MAN_W-1:0]};
                    flags_o[FLG_INX] = guard | sticky;
                end
            end
        endcase
    end

endmodule

// File: rtl/mul_float_pipe.sv
// Three-stage IEEE-754-style multiplier (unpack / mantissa multiply / round+pack)
// with valid/ready flow control; any output stall freezes the whole pipe.
module mul_float_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     a,
    input  logic [EXP_W+MAN_W:0]     b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     c,
    output logic [3:0]               flags
);

    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int EW2 = EXP_W + 2;
    localparam int PW  = 2 * MAN_W + 2;

    localparam logic signed [EW2-1:0] BIAS = EW2'(fp_bias(EXP_W));

    function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
        if (e == '0)
            return FP_ZERO;
        else if (&e)
            return (f == '0) ? FP_INF : FP_NAN;
        else
            return FP_NORM;
    endfunction

    logic                  stall;
    logic                  vld_p1_q, vld_p2_q, vld_p3_q;
    fp_class_e             cls_a, cls_b, cls_p1_d, cls_p1_q, cls_p2_q;
    logic                  inv_p1_d, inv_p1_q, inv_p2_q;
    logic                  sign_p1_q, sign_p2_q;
    logic signed [EW2-1:0] exp_p1_d, exp_p1_q, exp_p2_q;
    logic [MAN_W:0]        ma_p1_q, mb_p1_q;
    logic [PW-1:0]         prod_p2_q;
    logic [W-1:0]          rp_word, c_q;
    logic [3:0]            rp_flags, flags_q;

    assign stall     = vld_p3_q && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = vld_p3_q;
    assign c         = c_q;
    assign flags     = flags_q;

    assign cls_a    = classify(a[W-2 -: EXP_W], a[MAN_W-1:0]);
    assign cls_b    = classify(b[W-2 -: EXP_W], b[MAN_W-1:0]);
    assign exp_p1_d = $signed({2'b00, a[W-2 -: EXP_W]}) + $signed({2'b00, b[W-2 -: EXP_W]}) - BIAS;

    always_comb begin
        cls_p1_d = FP_NORM;
        inv_p1_d = 1'b0;
        if (cls_a == FP_NAN || cls_b == FP_NAN) begin
            cls_p1_d = FP_NAN;
        end else if ((cls_a == FP_INF && cls_b == FP_ZERO) || (cls_a == FP_ZERO && cls_b == FP_INF)) begin
            cls_p1_d = FP_NAN;
            inv_p1_d = 1'b1;
        end else if (cls_a == FP_INF || cls_b == FP_INF) begin
            cls_p1_d = FP_INF;
        end else if (cls_a == FP_ZERO || cls_b == FP_ZERO) begin
            cls_p1_d = FP_ZERO;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
            c_q      <= '0;
            flags_q  <= '0;
        end else if (!stall) begin
            vld_p1_q <= in_valid;
            vld_p2_q <= vld_p1_q;
            vld_p3_q <= vld_p2_q;
            if (vld_p2_q) begin
                c_q     <= rp_word;
                flags_q <= rp_flags;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!stall) begin
            // S1: unpacked operands, class and biased exponent sum
            sign_p1_q <= a[W-1] ^ b[W-1];
            exp_p1_q  <= exp_p1_d;
            cls_p1_q  <= cls_p1_d;
            inv_p1_q  <= inv_p1_d;
            ma_p1_q   <= {1'b1, a[MAN_W-1:0]};
            mb_p1_q   <= {1'b1, b[MAN_W-1:0]};
            // S2: full-width mantissa product
            sign_p2_q <= sign_p1_q;
            exp_p2_q  <= exp_p1_q;
            cls_p2_q  <= cls_p1_q;
            inv_p2_q  <= inv_p1_q;
            prod_p2_q <= PW'(ma_p1_q) * PW'(mb_p1_q);
        end
    end

    // S3: normalise, round and pack into the output register
    fp_round_pack #(
        .EXP_W(EXP_W),
        .MAN_W(MAN_W)
    ) u_round_pack (
        .sign_i    (sign_p2_q),
        .exp_i     (exp_p2_q),
        .prod_i    (prod_p2_q),
        .cls_i     (cls_p2_q),
        .invalid_i (inv_p2_q),
        .word_o    (rp_word),
        .flags_o   (rp_flags)
    );

endmodule

// File: tb/tb_mul_float_pipe.sv
// Bench for mul_float_pipe: binary32 vector table through a scoreboard, stall,
// reset-while-stalled, and one binary64 product on a second instance.
module tb_mul_float_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, c;
    logic [3:0]  flags;
    logic        in_valid64, in_ready64, out_valid64, out_ready64;
    logic [63:0] a64, b64, c64;
    logic [3:0]  flags64;

    always #5 clk = ~clk;

    mul_float_pipe #(.EXP_W(8), .MAN_W(23)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .c(c), .flags(flags)
    );

    mul_float_pipe #(.EXP_W(11), .MAN_W(52)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid64), .in_ready(in_ready64),
        .a(a64), .b(b64), .out_valid(out_valid64), .out_ready(out_ready64), .c(c64), .flags(flags64)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [3:0]  f;
    } vec_t;

    typedef struct {
        logic [31:0] c;
        logic [3:0]  f;
        bit          lat;
        int          acc;
    } exp_t;

    localparam int NV = 13;
    vec_t vecs[NV];
    exp_t sb[$];
    exp_t mon_e;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_out  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_out++;
            if (sb.size() == 0) begin
                chk("unexpected_output", 64'(c), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                mon_e = sb.pop_front();
                chk("c", 64'(c), 64'(mon_e.c));
                chk("flags", 64'(flags), 64'(mon_e.f));
                if (mon_e.lat)
                    chk("latency", 64'(cyc - mon_e.acc), 64'd3);
            end
        end
    end

    task automatic push_exp(input logic [31:0] ec, input logic [3:0] ef, input bit lat);
        exp_t e;
        e.c   = ec;
        e.f   = ef;
        e.lat = lat;
        e.acc = cyc;
        sb.push_back(e);
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic [31:0] tc,
                        input logic [3:0] tf, input bit lat);
        int w;
        w        = 0;
        a        = ta;
        b        = tb;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("in_ready_accept", 64'(in_ready), 64'd1);
        if (in_ready)
            push_exp(tc, tf, lat);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    int          n_acc;
    int          n0;
    int          acc64;
    int          w64;
    logic [31:0] op_a;

    initial begin
        vecs[0]  = '{32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000};
        vecs[1]  = '{32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000};
        vecs[2]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001};
        vecs[3]  = '{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 4'b0001};
        vecs[4]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101};
        vecs[5]  = '{32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011};
        vecs[6]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000};
        vecs[7]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0000};
        vecs[8]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000};
        vecs[9]  = '{32'h80000000, 32'h40000000, 32'h80000000, 4'b0000};
        vecs[10] = '{32'hFF800000, 32'hFF800000, 32'h7F800000, 4'b0000};
        vecs[11] = '{32'h00000001, 32'h40000000, 32'h00000000, 4'b0000};
        vecs[12] = '{32'h80800000, 32'h3F000000, 32'h80000000, 4'b0011};

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        a           = '0;
        b           = '0;
        out_ready   = 1'b1;
        in_valid64  = 1'b0;
        a64         = '0;
        b64         = '0;
        out_ready64 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_c", 64'(c), 64'd0);
        chk("rst_flags", 64'(flags), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid64", 64'(out_valid64), 64'd0);
        chk("rst_c64", c64, 64'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++)
            send(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].f, 1'b1);
        drain();

        // Six back-to-back ops into a blocked consumer.
        n0        = n_out;
        n_acc     = 0;
        out_ready = 1'b0;
        for (int cy = 0; cy < 6; cy++) begin
            op_a     = 32'h3F800000 + (32'(n_acc) << 20);
            a        = op_a;
            b        = 32'h40000000;
            in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) begin
                push_exp(op_a + 32'h00800000, 4'b0000, 1'b0);
                n_acc++;
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("stall_accepted", 64'(n_acc), 64'd3);
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            chk("stall_c_stable", 64'(c), 64'h40000000);
            chk("stall_flags_stable", 64'(flags), 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 3; i < 6; i++) begin
            op_a = 32'h3F800000 + (32'(i) << 20);
            send(op_a, 32'h40000000, op_a + 32'h00800000, 4'b0000, 1'b0);
        end
        in_valid = 1'b0;
        drain();
        chk("stall_out_count", 64'(n_out - n0), 64'd6);

        // Reset while two results are held in a stalled pipe.
        out_ready = 1'b0;
        send(32'h40400000, 32'h40400000, 32'h41100000, 4'b0000, 1'b0);
        send(32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("held_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        for (int k = 0; k < 5; k++) begin
            chk("post_rst_no_stale", 64'(out_valid), 64'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        send(32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 1'b1);
        drain();

        // binary64 instance: 1.5 x 2.0
        a64        = 64'h3FF8000000000000;
        b64        = 64'h4000000000000000;
        in_valid64 = 1'b1;
        @(negedge clk);
        chk("in_ready64", 64'(in_ready64), 64'd1);
        acc64 = cyc;
        @(posedge clk);
        #1;
        in_valid64 = 1'b0;
        w64        = 0;
        while (!out_valid64 && w64 < 10) begin
            @(negedge clk);
            w64++;
        end
        chk("out_valid64", 64'(out_valid64), 64'd1);
        chk("latency64", 64'(cyc - acc64), 64'd3);
        chk("c64", c64, 64'h4008000000000000);
        chk("flags64", 64'(flags64), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
